uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// ST_TAG exists only when UART_ARB_TAG_EN is defined.
package uart_arb_pkg;

    localparam int         NREQ_DEF   = 4;
    localparam int         DATA_W_DEF = 8;
    localparam logic [7:0] TAG_PREFIX = 8'hA0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
`ifdef UART_ARB_TAG_EN
        ST_TAG       = 3'd1,
`endif
        ST_START     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } arb_state_e;

    function automatic logic [7:0] tag_byte(input logic [7:0] id);
        return TAG_PREFIX | id;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin requester pick, starting one slot after the previous winner.
// Purely combinational, zero latency; no backpressure of its own.
// any_req_o is low when no requester is valid, in which case sel_o is 0.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] last_grant_i,
    output logic [$clog2(NREQ)-1:0] sel_o,
    output logic                    any_req_o
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] idx;

    always_comb begin
        sel_o     = '0;
        any_req_o = 1'b0;
        idx       = '0;
        // The previous winner is visited last, so it only wins again when alone.
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_grant_i) + k) % NREQ);
            if (!any_req_o && req_i[idx]) begin
                sel_o     = idx;
                any_req_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte requesters (round robin); UART_ARB_TAG_EN prefixes each byte with 0xA0|id.
// Latency: req_ready in the grant cycle, tx_start exactly one cycle later.
// Backpressure: no grant while tx_busy is high or a transfer is in flight.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     arb_busy
);

    localparam int IW = $clog2(NREQ);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     sel;
    logic              any_req;
    logic              grant_en;
    logic              armed_q;
    logic [DATA_W-1:0] txd_q, txd_d;
    logic [DATA_W-1:0] sel_byte;
`ifdef UART_ARB_TAG_EN
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              tag_phase_q, tag_phase_d;
`endif

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .sel_o        (sel),
        .any_req_o    (any_req)
    );

    assign sel_byte = req_data[sel*DATA_W +: DATA_W];

    // req_ready is decoded from IDLE, so armed_q keeps it low during and right after reset.
    assign grant_en = (state_q == ST_IDLE) && armed_q && any_req && !tx_busy;

    assign tx_data  = txd_q;
    assign grant_id = grant_q;
    assign arb_busy = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        txd_d       = txd_q;
        req_ready   = '0;
        tx_start    = 1'b0;
`ifdef UART_ARB_TAG_EN
        hold_d      = hold_q;
        tag_phase_d = tag_phase_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    req_ready[sel] = 1'b1;
                    grant_d        = sel;
                    last_d         = sel;
`ifdef UART_ARB_TAG_EN
                    hold_d         = sel_byte;
                    txd_d          = DATA_W'(tag_byte(8'(sel)));
                    state_d        = ST_TAG;
`else
                    txd_d          = sel_byte;
                    state_d        = ST_START;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                tx_start    = 1'b1;
                tag_phase_d = 1'b1;
                state_d     = ST_WAIT_ACK;
            end
`endif
            ST_START: begin
                tx_start = 1'b1;
                state_d  = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef UART_ARB_TAG_EN
                    // Tag frame finished: present the held data byte and send it.
                    if (tag_phase_q) begin
                        tag_phase_d = 1'b0;
                        txd_d       = hold_q;
                        state_d     = ST_START;
                    end else begin
                        state_d     = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= IW'(NREQ - 1);
            txd_q       <= '0;
            armed_q     <= 1'b0;
`ifdef UART_ARB_TAG_EN
            hold_q      <= '0;
            tag_phase_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            txd_q       <= txd_d;
            armed_q     <= 1'b1;
`ifdef UART_ARB_TAG_EN
            hold_q      <= hold_d;
            tag_phase_q <= tag_phase_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural transmitter; works with or without UART_ARB_TAG_EN.
module tb_uart_tx_arbiter;

    localparam int FRAME = 6;
`ifdef UART_ARB_TAG_EN
    localparam int EXP_SPACE = 2 * FRAME + 5;
`else
    localparam int EXP_SPACE = FRAME + 3;
`endif

    typedef struct packed {
        logic [7:0] dat;
        logic [1:0] gid;
        logic       after_rdy;
    } txexp_t;

    typedef struct {
        logic [3:0]       vld;
        logic [31:0]      dat;
        int               n;
        logic [4:0][1:0]  ord;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic [1:0]  grant_id;
    logic        arb_busy;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          gnt_cnt = 0;
    int          start_cnt = 0;
    int          tx_cnt = 0;
    int          prev_rdy_cyc = -1;
    bit          start_pend = 1'b0;
    bit          force_busy = 1'b0;
    bit          rdy_prev = 1'b0;
    logic [7:0]  last_byte = '0;

    txexp_t      exp_tx[$];
    logic [1:0]  exp_gnt[$];
    vec_t        vecs[6];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ   (4),
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] vld, input logic [31:0] dat, input int n,
                                input int o0, input int o1, input int o2, input int o3, input int o4);
        vec_t v;
        v.vld = vld;
        v.dat = dat;
        v.n   = n;
        v.ord[0] = 2'(o0);
        v.ord[1] = 2'(o1);
        v.ord[2] = 2'(o2);
        v.ord[3] = 2'(o3);
        v.ord[4] = 2'(o4);
        return v;
    endfunction

    task automatic push_grant(input logic [1:0] id, input logic [7:0] b);
        exp_gnt.push_back(id);
`ifdef UART_ARB_TAG_EN
        exp_tx.push_back('{dat: 8'hA0 | {6'b0, id}, gid: id, after_rdy: 1'b1});
        exp_tx.push_back('{dat: b, gid: id, after_rdy: 1'b0});
`else
        exp_tx.push_back('{dat: b, gid: id, after_rdy: 1'b1});
`endif
    endtask

    task automatic monitor();
        txexp_t e;
        if (req_ready != '0) begin
            gnt_cnt++;
            chk("rdy_onehot", 32'($countones(req_ready)), 32'd1);
            chk("rdy_with_valid", 32'((req_ready & req_valid) != '0), 32'd1);
            if (exp_gnt.size() == 0) chk("rdy_unexpected", 32'(req_ready), 32'd0);
            else chk("grant_order", 32'(onehot_idx(req_ready)), 32'(exp_gnt.pop_front()));
            if (prev_rdy_cyc >= 0) chk("rdy_spacing", 32'(cyc - prev_rdy_cyc), 32'(EXP_SPACE));
            prev_rdy_cyc = cyc;
        end
        if (tx_start) begin
            start_cnt++;
            start_pend = 1'b1;
            chk("start_while_busy", 32'(tx_busy), 32'd0);
            if (exp_tx.size() == 0) begin
                chk("start_unexpected", 32'(tx_start), 32'd0);
            end else begin
                e = exp_tx.pop_front();
                chk("tx_data", 32'(tx_data), 32'(e.dat));
                chk("grant_id", 32'(grant_id), 32'(e.gid));
                chk("start_latency", 32'(rdy_prev), 32'(e.after_rdy));
            end
            last_byte = tx_data;
        end else if (tx_cnt > 0) begin
            chk("tx_data_hold", 32'(tx_data), 32'(last_byte));
        end
        rdy_prev = (req_ready != '0);
    endtask

    // One clock: sample outputs at the falling edge, then advance the transmitter model.
    task automatic tick();
        @(negedge clk);
        if (rst_n) monitor();
        else rdy_prev = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        if (start_pend) begin
            tx_cnt     = FRAME;
            start_pend = 1'b0;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
        end
        tx_busy = force_busy || (tx_cnt > 0);
    endtask

    task automatic wait_gnt(input int target, input string nm);
        int b = 0;
        while (gnt_cnt < target && b < 400) begin
            tick();
            b++;
        end
        chk({nm, "_grant_count"}, 32'(gnt_cnt), 32'(target));
    endtask

    task automatic drain(input string nm);
        int b = 0;
        while ((exp_tx.size() != 0 || arb_busy) && b < 400) begin
            tick();
            b++;
        end
        chk({nm, "_drain"}, 32'(exp_tx.size()), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic [31:0] d;
        d = v.dat;
        prev_rdy_cyc = -1;
        for (int k = 0; k < v.n; k++) push_grant(v.ord[k], d[8*v.ord[k] +: 8]);
        req_data  = d;
        req_valid = v.vld;
        wait_gnt(gnt_cnt + v.n, nm);
        req_valid = '0;
        drain(nm);
    endtask

    initial begin
        int b;
        int g0;
        int s0;

        // Round-robin orders assume last_grant carried over from the previous vector.
        vecs[0] = mk(4'b0001, 32'h0000_0055, 1, 0, 0, 0, 0, 0);
        vecs[1] = mk(4'b1000, 32'hAB00_0000, 1, 3, 0, 0, 0, 0);
        vecs[2] = mk(4'b1111, 32'h4433_2211, 5, 0, 1, 2, 3, 0);
        vecs[3] = mk(4'b0110, 32'h00C3_B200, 3, 1, 2, 1, 0, 0);
        vecs[4] = mk(4'b1001, 32'h9900_0066, 2, 3, 0, 0, 0, 0);
        vecs[5] = mk(4'b0101, 32'h00E7_00D4, 2, 2, 0, 0, 0, 0);

        req_valid = 4'b1111;
        req_data  = 32'h1122_3344;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_arb_busy", 32'(arb_busy), 32'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Transmitter already busy: nothing may be granted until it goes idle.
        prev_rdy_cyc = -1;
        force_busy   = 1'b1;
        tick();
        push_grant(2'd1, 8'h99);
        g0 = gnt_cnt;
        s0 = start_cnt;
        req_data  = 32'h0000_9900;
        req_valid = 4'b0010;
        repeat (20) tick();
        chk("busy_block_rdy", 32'(gnt_cnt - g0), 32'd0);
        chk("busy_block_start", 32'(start_cnt - s0), 32'd0);
        force_busy = 1'b0;
        wait_gnt(g0 + 1, "busy_release");
        req_valid = '0;
        drain("busy_release");

        // Valid and data withdrawn right after the handshake: captured byte must survive.
        prev_rdy_cyc = -1;
        push_grant(2'd2, 8'h3C);
        req_data  = 32'h003C_0000;
        req_valid = 4'b0100;
        wait_gnt(gnt_cnt + 1, "drop");
        req_valid = '0;
        req_data  = 32'hFFFF_FFFF;
        drain("drop");

        // Reset while waiting for the frame to finish.
        prev_rdy_cyc = -1;
        push_grant(2'd0, 8'h77);
        req_data  = 32'h0000_0077;
        req_valid = 4'b0001;
        wait_gnt(gnt_cnt + 1, "mid_rst");
        req_valid = '0;
        b = 0;
        while (!tx_busy && b < 100) begin
            tick();
            b++;
        end
        tick();
        tick();
        chk("pre_rst_arb_busy", 32'(arb_busy), 32'd1);
        rst_n      = 1'b0;
        tx_cnt     = 0;
        start_pend = 1'b0;
        tx_busy    = 1'b0;
        exp_tx.delete();
        exp_gnt.delete();
        req_data  = 32'h0000_BBAA;
        req_valid = 4'b0011;
        @(negedge clk);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
        chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
        chk("mid_rst_arb_busy", 32'(arb_busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_vec(mk(4'b0011, 32'h0000_BBAA, 2, 0, 1, 0, 0, 0), "post_rst");

        chk("exp_gnt_left", 32'(exp_gnt.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
